// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin byte scheduler sharing one UART transmitter between kb and term
// Optional CR -> CR LF insertion is enabled by defining UART_TX_CRLF_EN.
module uart_tx_scheduler #(
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbValid,
    input  logic [7:0] kbData,
    output logic       kbReady,
    input  logic       termValid,
    input  logic [7:0] termData,
    output logic       termReady,
    output logic       txStart,
    output logic [7:0] txData,
    input  logic       txBusy,
    output logic [1:0] overflow,
    output logic       timeoutErr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

`ifdef UART_TX_CRLF_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_INSERT_LF} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} state_t;
`endif

    state_t        r_state;
    logic          r_tx_start;
    logic [7:0]    r_tx_data;
    logic          r_prefer_term;
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout_err;

    logic [1:0] w_push_req;
    logic [1:0] w_ready;
    logic [1:0] w_nonempty;
    logic [1:0] w_pop;
    logic [1:0] w_ovf;
    logic [7:0] w_in_data [2];
    logic [7:0] w_head [2];
    logic       w_grant_kb;
    logic       w_grant_term;
    state_t     w_after;

    assign w_push_req   = {termValid, kbValid};
    assign w_in_data[0] = kbData;
    assign w_in_data[1] = termData;

    // Index 0 is the keyboard FIFO, index 1 the terminal-reply FIFO.
    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [7:0]    r_mem [DEPTH];
        logic [AW-1:0] r_wp;
        logic [AW-1:0] r_rp;
        logic [CW-1:0] r_cnt;
        logic          r_ovf;
        logic          w_push;

        assign w_ready[g]    = (r_cnt != FULL);
        assign w_nonempty[g] = (r_cnt != '0);
        assign w_push        = w_push_req[g] && w_ready[g];
        assign w_head[g]     = r_mem[r_rp];
        assign w_ovf[g]      = r_ovf;

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wp] <= w_in_data[g];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wp <= r_wp + 1'b1;
                end
                if (w_pop[g]) begin
                    r_rp <= r_rp + 1'b1;
                end
                if (w_push && !w_pop[g]) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (!w_push && w_pop[g]) begin
                    r_cnt <= r_cnt - 1'b1;
                end
                if (w_push_req[g] && !w_ready[g]) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign w_grant_kb   = w_nonempty[0] && (!w_nonempty[1] || !r_prefer_term);
    assign w_grant_term = w_nonempty[1] && !w_grant_kb;
    assign w_pop        = {w_grant_term, w_grant_kb} & {2{r_state == S_IDLE}};

`ifdef UART_TX_CRLF_EN
    assign w_after = (r_tx_data == 8'h0D) ? S_INSERT_LF : S_IDLE;
`else
    assign w_after = S_IDLE;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_prefer_term <= 1'b0;
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_kb || w_grant_term) begin
                        r_tx_data     <= w_grant_kb ? w_head[0] : w_head[1];
                        r_prefer_term <= w_grant_kb;
                        r_tx_start    <= 1'b1;
                        r_state       <= S_START;
                    end
                end
                S_START: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (txBusy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= w_after;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!txBusy) begin
                        r_state <= w_after;
                    end
                end
`ifdef UART_TX_CRLF_EN
                // The inserted LF bypasses the FIFOs and leaves the arbiter pointer alone.
                S_INSERT_LF: begin
                    r_tx_data  <= 8'h0A;
                    r_tx_start <= 1'b1;
                    r_state    <= S_START;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign kbReady    = w_ready[0];
    assign termReady  = w_ready[1];
    assign txStart    = r_tx_start;
    assign txData     = r_tx_data;
    assign overflow   = w_ovf;
    assign timeoutErr = r_timeout_err;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
    localparam int DEPTH = 8;
    localparam int BT    = 16;
`ifdef UART_TX_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       kbValid = 1'b0;
    logic [7:0] kbData = 8'h00;
    logic       termValid = 1'b0;
    logic [7:0] termData = 8'h00;
    logic       txBusy = 1'b0;
    logic       kbReady;
    logic       termReady;
    logic       txStart;
    logic [7:0] txData;
    logic [1:0] overflow;
    logic       timeoutErr;

    uart_tx_scheduler #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst),
        .kbValid(kbValid), .kbData(kbData), .kbReady(kbReady),
        .termValid(termValid), .termData(termData), .termReady(termReady),
        .txStart(txStart), .txData(txData), .txBusy(txBusy),
        .overflow(overflow), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [7:0] d; int len; } exp_t;
    typedef struct { int cyc; logic [7:0] d; } obs_t;

    exp_t       expq[$];
    obs_t       log_q[$];
    logic [7:0] kbq[$];
    logic [7:0] tq[$];
    int         cyc = 0;
    int         m_free_from = 0;
    int         m_lf_at = -1;
    int         m_to_at = -1;
    int         busy_rem = 0;
    bit         m_pref_term = 1'b0;
    bit         m_terr = 1'b0;
    logic [1:0] m_ovf = 2'b00;
    logic [7:0] m_last = 8'h00;
    int         tx_mode = 1;
    int         tx_fixed = 20;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Busy length the transmitter will use for a byte: 0 means it never answers.
    function automatic int pick_len();
        if (tx_mode == 2) return 0;
        if (tx_mode == 1) return tx_fixed;
        return ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
    endfunction

    // A grant in cycle cyc means START in cyc+1; the sequencer is free again once the handshake ends.
    task automatic schedule(input logic [7:0] byte_v);
        int s;
        int len;
        s   = cyc + 1;
        len = pick_len();
        expq.push_back('{s, byte_v, len});
        m_free_from = (len > 0) ? s + len + 2 : s + 1 + BT;
        if (len == 0) m_to_at = s + BT;
        if (CRLF && byte_v == 8'h0D) m_lf_at = m_free_from;
    endtask

    task automatic model_step();
        bit kr;
        bit tr;
        if (!rst) begin
            kbq.delete(); tq.delete(); expq.delete();
            m_free_from = 0; m_lf_at = -1; m_to_at = -1;
            m_pref_term = 1'b0; m_terr = 1'b0; m_ovf = 2'b00;
        end else begin
            kr = kbq.size() < DEPTH;
            tr = tq.size() < DEPTH;
            if (cyc == m_lf_at) begin
                m_lf_at = -1;
                schedule(8'h0A);
            end else if (cyc >= m_free_from && m_lf_at < 0 && (kbq.size() > 0 || tq.size() > 0)) begin
                if (kbq.size() > 0 && (tq.size() == 0 || !m_pref_term)) begin
                    m_pref_term = 1'b1;
                    schedule(kbq.pop_front());
                end else begin
                    m_pref_term = 1'b0;
                    schedule(tq.pop_front());
                end
            end
            if (cyc == m_to_at) m_terr = 1'b1;
            if (kbValid) begin
                if (kr) kbq.push_back(kbData); else m_ovf[0] = 1'b1;
            end
            if (termValid) begin
                if (tr) tq.push_back(termData); else m_ovf[1] = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic compare_step();
        bit e;
        if (!rst) begin
            txBusy = 1'b0; busy_rem = 0; m_last = 8'h00;
        end else begin
            txBusy = (busy_rem > 0);
            if (busy_rem > 0) busy_rem--;
            e = (expq.size() > 0) && (expq[0].cyc == cyc);
            chk("txStart", txStart, e);
            if (e) begin
                chk("txData_at_start", txData, expq[0].d);
                m_last   = expq[0].d;
                busy_rem = expq[0].len;
                void'(expq.pop_front());
            end else if (txStart) begin
                busy_rem = 1;
            end
            if (txStart) log_q.push_back('{cyc, txData});
            chk("txData_hold", txData, m_last);
            chk("kbReady", kbReady, kbq.size() < DEPTH);
            chk("termReady", termReady, tq.size() < DEPTH);
            chk("overflow", overflow, m_ovf);
            chk("timeoutErr", timeoutErr, m_terr);
        end
    endtask

    task automatic tick(input bit kv, input logic [7:0] kd, input bit tv, input logic [7:0] td);
        kbValid = kv; kbData = kd; termValid = tv; termData = td;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_step();
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        repeat (2) tick(0, 0, 0, 0);
        rst = 1'b1;
        log_q.delete();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((kbq.size() > 0 || tq.size() > 0 || expq.size() > 0 || cyc < m_free_from || m_lf_at >= 0) && k < 4000) begin
            tick(0, 0, 0, 0);
            k++;
        end
        chk("drain_bound", k < 4000, 1);
        repeat (3) tick(0, 0, 0, 0);
    endtask

    task automatic check_log(input string nm, input logic [7:0] el[$]);
        chk({nm, "_count"}, log_q.size(), el.size());
        for (int i = 0; i < el.size() && i < log_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", nm, i), log_q[i].d, el[i]);
        end
    endtask

    initial begin
        int p;
        logic [7:0] el[$];
        bit kv;
        bit tv;

        do_reset();
        chk("reset_kbReady", kbReady, 1);
        chk("reset_termReady", termReady, 1);
        chk("reset_txData", txData, 8'h00);

        tx_mode = 1; tx_fixed = 20;
        p = cyc;
        tick(1, 8'h41, 0, 0);
        drain();
        el = '{8'h41};
        check_log("single", el);
        if (log_q.size() > 0) chk("single_latency", log_q[0].cyc - p, 2);

        do_reset();
        tx_fixed = 4;
        tick(1, 8'h61, 1, 8'h1B);
        tick(1, 8'h62, 1, 8'h5B);
        drain();
        el = '{8'h61, 8'h1B, 8'h62, 8'h5B};
        check_log("rr", el);

        do_reset();
        tx_fixed = 20;
        tick(0, 0, 1, 8'hEE);
        repeat (3) tick(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            tick(1, 8'h10 + 8'(i), 0, 0);
            if (i == 7) chk("ovf_kbReady_low", kbReady, 0);
        end
        chk("ovf_flags", overflow, 2'b01);
        drain();
        el = '{8'hEE, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        check_log("ovf", el);

        do_reset();
        tx_mode = 2;
        tick(1, 8'hA1, 0, 0);
        tick(1, 8'hA2, 0, 0);
        drain();
        chk("to_flag", timeoutErr, 1);
        el = '{8'hA1, 8'hA2};
        check_log("to", el);
        if (log_q.size() > 1) chk("to_spacing", log_q[1].cyc - log_q[0].cyc, BT + 2);

        do_reset();
        tx_mode = 1; tx_fixed = 20;
        for (int i = 0; i < 4; i++) tick(1, 8'h50 + 8'(i), 0, 0);
        repeat (6) tick(0, 0, 0, 0);
        #1 rst = 1'b0;
        #1;
        chk("arst_txStart", txStart, 0);
        chk("arst_txData", txData, 8'h00);
        chk("arst_overflow", overflow, 2'b00);
        chk("arst_timeoutErr", timeoutErr, 0);
        chk("arst_kbReady", kbReady, 1);
        chk("arst_termReady", termReady, 1);
        repeat (2) tick(0, 0, 0, 0);
        rst = 1'b1;
        log_q.delete();
        repeat (40) tick(0, 0, 0, 0);
        chk("arst_no_start", log_q.size(), 0);

        do_reset();
        tx_fixed = 3;
        tick(1, 8'h0D, 0, 0);
        tick(1, 8'h31, 0, 0);
        drain();
`ifdef UART_TX_CRLF_EN
        el = '{8'h0D, 8'h0A, 8'h31};
`else
        el = '{8'h0D, 8'h31};
`endif
        check_log("crlf", el);

        do_reset();
        tx_mode = 0;
        repeat (3000) begin
            kv = ($urandom_range(0, 99) < 35);
            tv = ($urandom_range(0, 99) < 35);
            tick(kv, ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom),
                 tv, ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
